// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART transmit arbiter.
package uart_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2
    } state_t;

    localparam logic SRC1 = 1'b0;
    localparam logic SRC2 = 1'b1;

    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 200000;

endpackage

// File: rtl/uart_arb_watchdog.sv
// Transaction watchdog: loads CYCLES-1 on clear, counts down while enabled,
// and flags expiry once the count hits zero.
module uart_arb_watchdog #(
    parameter int unsigned CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned    WIDTH = $clog2(CYCLES + 1);
    localparam logic [WIDTH-1:0] LOAD = WIDTH'(CYCLES - 1);

    logic [WIDTH-1:0] count;

    // Down-counter; clear has priority over counting, zero is a floor.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= LOAD;
        end else if (enable && (count != '0)) begin
            count <= count - WIDTH'(1);
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/uart_tx_arbiter.sv
// Two-source arbiter in front of a shared UART TX core. Captures the winning
// byte, acks the source, starts the core and holds the byte until the frame
// ends or the watchdog aborts it.
// Optional feature: define UART_ARB_ROUND_ROBIN_EN for round-robin arbitration;
// otherwise source 1 has fixed priority.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       req1_i,
    input  logic [7:0] data1_i,
    input  logic       req2_i,
    input  logic [7:0] data2_i,
    output logic       ack1_o,
    output logic       ack2_o,
    input  logic       tx_busy_i,
    input  logic       tx_done_i,
    output logic       tx_start_o,
    output logic [7:0] tx_data_o,
    output logic       owner_o,
    output logic       busy_o,
    output logic       err_o
);

    state_t     state, state_next;
    logic       ack1_next, ack2_next, start_next, owner_next, err_next;
    logic [7:0] data_next;
    logic       capture, winner, expired;

`ifdef UART_ARB_ROUND_ROBIN_EN
    logic ptr;

    // Winner selection: pointer breaks ties between simultaneous requests.
    always_comb begin
        if (req1_i && req2_i) begin
            winner = ptr;
        end else if (req1_i) begin
            winner = SRC1;
        end else begin
            winner = SRC2;
        end
    end

    // Pointer favours the source not granted last once a transaction ends.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            ptr <= SRC1;
        end else if ((state != IDLE) && (state_next == IDLE)) begin
            ptr <= ~owner_o;
        end
    end
`else
    // Winner selection: source 1 always wins a tie.
    always_comb begin
        winner = req1_i ? SRC1 : SRC2;
    end
`endif

    // Next-state and next-output logic; all outputs are registered below.
    always_comb begin
        state_next = state;
        ack1_next  = 1'b0;
        ack2_next  = 1'b0;
        start_next = 1'b0;
        data_next  = tx_data_o;
        owner_next = owner_o;
        err_next   = err_o;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                if (req1_i || req2_i) begin
                    capture    = 1'b1;
                    data_next  = (winner == SRC2) ? data2_i : data1_i;
                    owner_next = winner;
                    ack1_next  = (winner == SRC1);
                    ack2_next  = (winner == SRC2);
                    state_next = START;
                end
            end
            START: begin
                // An expired watchdog aborts even if the core just went idle.
                if (expired) begin
                    err_next   = 1'b1;
                    state_next = IDLE;
                end else if (!tx_busy_i) begin
                    start_next = 1'b1;
                    state_next = WAIT;
                end
            end
            WAIT: begin
                // A genuine completion on the expiry edge is not an error.
                if (tx_done_i) begin
                    state_next = IDLE;
                end else if (expired) begin
                    err_next   = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state      <= IDLE;
            ack1_o     <= 1'b0;
            ack2_o     <= 1'b0;
            tx_start_o <= 1'b0;
            tx_data_o  <= '0;
            owner_o    <= SRC1;
            err_o      <= 1'b0;
        end else begin
            state      <= state_next;
            ack1_o     <= ack1_next;
            ack2_o     <= ack2_next;
            tx_start_o <= start_next;
            tx_data_o  <= data_next;
            owner_o    <= owner_next;
            err_o      <= err_next;
        end
    end

    assign busy_o = (state != IDLE);

    uart_arb_watchdog #(
        .CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (clk_i),
        .reset  (reset_i),
        .clear  (capture),
        .enable (state != IDLE),
        .expired(expired)
    );

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: expected grants are queued by the
// stimulus and consumed by monitors watching the ack and tx_start pulses.
module tb_uart_tx_arbiter;

    typedef struct packed {
        logic [7:0] data;
        logic       owner;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset, req1, req2, tx_busy, tx_done;
    logic [7:0] data1, data2;
    logic       ack1, ack2, tx_start, owner, busy, err;
    logic [7:0] tx_data;

    int   checks = 0;
    int   errors = 0;
    exp_t ack_q[$];
    exp_t tx_q[$];

    uart_tx_arbiter #(.TIMEOUT_CYCLES(16)) dut (
        .clk_i     (clk),
        .reset_i   (reset),
        .req1_i    (req1),
        .data1_i   (data1),
        .req2_i    (req2),
        .data2_i   (data2),
        .ack1_o    (ack1),
        .ack2_o    (ack2),
        .tx_busy_i (tx_busy),
        .tx_done_i (tx_done),
        .tx_start_o(tx_start),
        .tx_data_o (tx_data),
        .owner_o   (owner),
        .busy_o    (busy),
        .err_o     (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d, input logic o);
        exp_t e;
        e.data  = d;
        e.owner = o;
        ack_q.push_back(e);
        tx_q.push_back(e);
    endtask

    task automatic wait_start(input string name);
        int n;
        n = 0;
        while (!tx_start && n < 40) begin
            tick();
            n++;
        end
        checks++;
        if (!tx_start) begin
            errors++;
            $display("FAIL %s: tx_start never seen in 40 cycles, required a pulse", name);
        end
    endtask

    task automatic finish_frame();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Ack monitor: each ack must match the next queued grant.
    always @(negedge clk) begin
        exp_t e;
        if (ack1 || ack2) begin
            if (ack_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL ack_unexpected: got ack1=%0b ack2=%0b, required none", ack1, ack2);
            end else begin
                e = ack_q.pop_front();
                check("ack_source", {ack2, ack1}, e.owner ? 2'b10 : 2'b01);
                check("ack_data", tx_data, e.data);
            end
        end
    end

    // Start monitor: each start pulse must carry the next queued byte.
    always @(negedge clk) begin
        exp_t e;
        if (tx_start) begin
            if (tx_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL start_unexpected: got tx_start with data 0x%0h, required none", tx_data);
            end else begin
                e = tx_q.pop_front();
                check("start_data", tx_data, e.data);
                check("start_owner", owner, e.owner);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1, "bench timeout");
    end

    initial begin
        reset = 1'b1; req1 = 1'b0; req2 = 1'b0; data1 = '0; data2 = '0;
        tx_busy = 1'b0; tx_done = 1'b0;
        tick(); tick(); tick();
        check("reset_outputs", {ack1, ack2, tx_start, tx_data, owner, busy, err}, '0);
        reset = 1'b0;
        tick();

        // Single source 1 request, done 10 cycles after start.
        push(8'h41, 1'b0);
        req1 = 1'b1; data1 = 8'h41;
        tick();
        check("t1_ack1", ack1, 1);
        check("t1_data", tx_data, 8'h41);
        check("t1_owner", owner, 0);
        check("t1_busy_capture", busy, 1);
        check("t1_no_early_start", tx_start, 0);
        req1 = 1'b0;
        tick();
        check("t1_start", tx_start, 1);
        repeat (10) tick();
        check("t1_busy_waiting", busy, 1);
        finish_frame();
        check("t1_idle_after_done", busy, 0);
        check("t1_data_held", tx_data, 8'h41);
        check("t1_no_err", err, 0);

        // Simultaneous requests over four frames, then source 1 drops.
        do_reset();
`ifdef UART_ARB_ROUND_ROBIN_EN
        push(8'h11, 1'b0); push(8'h22, 1'b1); push(8'h11, 1'b0); push(8'h22, 1'b1);
`else
        push(8'h11, 1'b0); push(8'h11, 1'b0); push(8'h11, 1'b0); push(8'h11, 1'b0);
`endif
        push(8'h22, 1'b1);
        req1 = 1'b1; data1 = 8'h11; req2 = 1'b1; data2 = 8'h22;
        for (int f = 0; f < 4; f++) begin
            wait_start("t2_frame");
            if (f == 3) req1 = 1'b0;
            finish_frame();
        end
        wait_start("t2_pending_src2");
        req2 = 1'b0;
        finish_frame();
        check("t2_owner_last", owner, 1);

        // Core busy for five cycles after capture: one start when it frees.
        tick();
        tx_busy = 1'b1;
        push(8'h3C, 1'b0);
        req1 = 1'b1; data1 = 8'h3C;
        tick();
        check("t3_ack1", ack1, 1);
        req1 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("t3_held_in_start", {tx_start, busy}, 2'b01);
            tick();
        end
        tx_busy = 1'b0;
        check("t3_still_start", tx_start, 0);
        tick();
        check("t3_start_pulse", tx_start, 1);
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        check("t3_single_pulse", {tx_start, busy}, 2'b00);

        // Watchdog: no done, abort 16 cycles after capture, err sticks.
        push(8'h77, 1'b0);
        req1 = 1'b1; data1 = 8'h77;
        tick();
        req1 = 1'b0;
        for (int k = 1; k < 16; k++) begin
            tick();
            check("t4_active", {busy, err}, 2'b10);
        end
        tick();
        check("t4_timeout_idle_err", {busy, err}, 2'b01);
        push(8'h99, 1'b1);
        req2 = 1'b1; data2 = 8'h99;
        tick();
        check("t4_next_ack2", ack2, 1);
        req2 = 1'b0;
        wait_start("t4_next_served");
        finish_frame();
        check("t4_err_sticky", err, 1);

        // Reset in WAIT with source 2 pending.
        push(8'hA5, 1'b0);
        req1 = 1'b1; data1 = 8'hA5;
        tick();
        req1 = 1'b0;
        tick();
        check("t5_in_wait", {tx_start, busy}, 2'b11);
        req2 = 1'b1; data2 = 8'h5A;
        reset = 1'b1;
        tick();
        check("t5_reset_outputs", {ack1, ack2, tx_start, tx_data, owner, busy, err}, '0);
        reset = 1'b0;
        push(8'h5A, 1'b1);
        tick();
        check("t5_ack2", ack2, 1);
        check("t5_data", tx_data, 8'h5A);
        req2 = 1'b0;
        wait_start("t5_served");
        finish_frame();

        // Stray done in IDLE does nothing.
        tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        check("t6_stray_done", {ack1, ack2, tx_start, busy}, 4'b0000);
        tick();
        check("t6_still_idle", busy, 0);

        tick(); tick();
        check("ack_queue_drained", ack_q.size(), 0);
        check("tx_queue_drained", tx_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
